// File: rtl/tl_demux_pipe.sv
// tl_demux_pipe: registered 1-to-N TileLink channel demux with burst route locking
// and out-of-range select discard. Define TL_DEMUX_PIPE_BEAT_CNT_EN for per-port beat counters.
module tl_demux_pipe #(
   parameter int unsigned N      = 4,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned SEL_W  = 2,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [DATA_W-1:0]   data_i,
   input  logic [SEL_W-1:0]    sel_i,
   input  logic                last_i,
   output logic [N-1:0]        valid_o,
   input  logic [N-1:0]        ready_i,
   output logic [N*DATA_W-1:0] data_o,
   output logic                last_o,
   output logic                lock_o,
`ifdef TL_DEMUX_PIPE_BEAT_CNT_EN
   input  logic                cnt_clr_i,
   output logic [N*CNT_W-1:0]  beat_cnt_o,
`endif
   output logic                err_o,
   output logic [SEL_W-1:0]    err_sel_o
);

   localparam int unsigned SEL_N    = 2**SEL_W;
   localparam bit          FULL_MAP = (N == SEL_N);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              last_q, last_d;
   logic              lock_q, lock_d;
   logic [SEL_W-1:0]  lock_sel_q, lock_sel_d;
   logic              err_q, err_d;
   logic [SEL_W-1:0]  err_sel_q, err_sel_d;

   logic [SEL_N-1:0]  ready_ext_c;
   logic              deq_c;
   logic              accept_c;
   logic              in_range_c;
   logic [SEL_W-1:0]  eff_sel_c;

   // Zero-extend ready so indexing by any select value stays in bounds.
   assign ready_ext_c = SEL_N'(ready_i);
   assign deq_c       = valid_q && ready_ext_c[sel_q];
   assign ready_o     = !valid_q || deq_c;
   assign accept_c    = valid_i && ready_o;
   assign eff_sel_c   = lock_q ? lock_sel_q : sel_i;
   assign in_range_c  = FULL_MAP || ({1'b0, eff_sel_c} < (SEL_W+1)'(N));

   always_comb begin
      valid_o = '0;
      for (int unsigned i = 0; i < N; i++) begin
         valid_o[i] = valid_q && (sel_q == SEL_W'(i));
      end
   end

   assign data_o    = {N{data_q}};
   assign last_o    = last_q;
   assign lock_o    = lock_q;
   assign err_o     = err_q;
   assign err_sel_o = err_sel_q;

   // Output register, burst lock and error capture.
   always_comb begin
      valid_d    = valid_q;
      data_d     = data_q;
      sel_d      = sel_q;
      last_d     = last_q;
      lock_d     = lock_q;
      lock_sel_d = lock_sel_q;
      err_d      = 1'b0;
      err_sel_d  = err_sel_q;
      if (deq_c) begin
         valid_d = 1'b0;
      end
      if (accept_c) begin
         if (in_range_c) begin
            valid_d = 1'b1;
            data_d  = data_i;
            sel_d   = eff_sel_c;
            last_d  = last_i;
         end else if (!lock_q) begin
            err_d     = 1'b1;
            err_sel_d = eff_sel_c;
         end
         // Locking also covers discarded messages so their tail beats stay dropped.
         if (last_i) begin
            lock_d = 1'b0;
         end else if (!lock_q) begin
            lock_d     = 1'b1;
            lock_sel_d = sel_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q    <= 1'b0;
         data_q     <= '0;
         sel_q      <= '0;
         last_q     <= 1'b0;
         lock_q     <= 1'b0;
         lock_sel_q <= '0;
         err_q      <= 1'b0;
         err_sel_q  <= '0;
      end else begin
         valid_q    <= valid_d;
         data_q     <= data_d;
         sel_q      <= sel_d;
         last_q     <= last_d;
         lock_q     <= lock_d;
         lock_sel_q <= lock_sel_d;
         err_q      <= err_d;
         err_sel_q  <= err_sel_d;
      end
   end

`ifdef TL_DEMUX_PIPE_BEAT_CNT_EN
   logic [N*CNT_W-1:0] cnt_q, cnt_d;

   // Saturating per-port dequeue counters; clear wins over increment.
   always_comb begin
      cnt_d = cnt_q;
      for (int unsigned i = 0; i < N; i++) begin
         if (cnt_clr_i) begin
            cnt_d[i*CNT_W +: CNT_W] = '0;
         end else if (valid_o[i] && ready_i[i] && (cnt_q[i*CNT_W +: CNT_W] != '1)) begin
            cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign beat_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_tl_demux_pipe.sv
// Bench for tl_demux_pipe: message-level routing model with per-cycle compare on an N=4
// instance, plus directed literal checks including an N=3 instance for out-of-range selects.
module tb_tl_demux_pipe;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 64;
   localparam int unsigned SW = 2;
   localparam int unsigned CW = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            valid_i;
   logic            ready_o;
   logic [DW-1:0]   data_i;
   logic [SW-1:0]   sel_i;
   logic            last_i;
   logic [N-1:0]    valid_o;
   logic [N-1:0]    ready_i;
   logic [N*DW-1:0] data_o;
   logic            last_o;
   logic            lock_o;
   logic            err_o;
   logic [SW-1:0]   err_sel_o;
`ifdef TL_DEMUX_PIPE_BEAT_CNT_EN
   logic            cnt_clr_i;
   logic [N*CW-1:0] beat_cnt_o;
`endif

   logic            v3, ro3, l3, lo3, lk3, e3;
   logic [DW-1:0]   d3;
   logic [SW-1:0]   s3, es3;
   logic [2:0]      vo3, r3;
   logic [3*DW-1:0] do3;
`ifdef TL_DEMUX_PIPE_BEAT_CNT_EN
   logic            clr3;
   logic [3*CW-1:0] cnt3;
`endif

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;
   bit tog_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tl_demux_pipe #(.N(N), .DATA_W(DW), .SEL_W(SW), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
      .data_i(data_i), .sel_i(sel_i), .last_i(last_i), .valid_o(valid_o),
      .ready_i(ready_i), .data_o(data_o), .last_o(last_o), .lock_o(lock_o),
`ifdef TL_DEMUX_PIPE_BEAT_CNT_EN
      .cnt_clr_i(cnt_clr_i), .beat_cnt_o(beat_cnt_o),
`endif
      .err_o(err_o), .err_sel_o(err_sel_o)
   );

   tl_demux_pipe #(.N(3), .DATA_W(DW), .SEL_W(SW), .CNT_W(CW)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v3), .ready_o(ro3),
      .data_i(d3), .sel_i(s3), .last_i(l3), .valid_o(vo3),
      .ready_i(r3), .data_o(do3), .last_o(lo3), .lock_o(lk3),
`ifdef TL_DEMUX_PIPE_BEAT_CNT_EN
      .cnt_clr_i(clr3), .beat_cnt_o(cnt3),
`endif
      .err_o(e3), .err_sel_o(es3)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Message-level model: each message goes to its first beat's select, or is dropped.
   typedef struct packed {
      logic [SW-1:0] port;
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   beat_t         exp_q[$];
   bit            m_in_msg, m_drop, m_err, m_rdy, m_last;
   logic [SW-1:0] m_dest, m_err_sel;
   logic [DW-1:0] m_hold;
   logic [N-1:0]  m_expv;
   int            m_deq[N];

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_in_msg  = 1'b0;
         m_drop    = 1'b0;
         m_err     = 1'b0;
         m_err_sel = '0;
         m_hold    = '0;
         m_last    = 1'b0;
         m_dest    = '0;
      end else begin
         m_expv = (exp_q.size() != 0) ? (N'(1) << exp_q[0].port) : '0;
         chk("valid_o", 64'(valid_o), 64'(m_expv));
         chk("data_o_lo", data_o[DW-1:0], m_hold);
         chk("data_o_hi", data_o[N*DW-1 -: DW], m_hold);
         chk("last_o", 64'(last_o), 64'(m_last));
         chk("lock_o", 64'(lock_o), 64'(m_in_msg));
         chk("err_o", 64'(err_o), 64'(m_err));
         chk("err_sel_o", 64'(err_sel_o), 64'(m_err_sel));
         m_rdy = (exp_q.size() == 0) || ready_i[exp_q[0].port];
         chk("ready_o", 64'(ready_o), 64'(m_rdy));
         if (exp_q.size() != 0 && ready_i[exp_q[0].port]) begin
            m_deq[exp_q[0].port]++;
            void'(exp_q.pop_front());
         end
         m_err = 1'b0;
         if (valid_i && m_rdy) begin
            if (!m_in_msg) begin
               m_dest = sel_i;
               m_drop = (int'(sel_i) >= int'(N));
               if (m_drop) begin
                  m_err     = 1'b1;
                  m_err_sel = sel_i;
               end
            end
            if (!m_drop) begin
               exp_q.push_back('{port: m_dest, data: data_i, last: last_i});
               m_hold = data_i;
               m_last = last_i;
            end
            m_in_msg = !last_i;
         end
      end
   end

   always begin
      @(posedge clk);
      #1;
      if (tog_en) ready_i[1] = ~ready_i[1];
   end

   task automatic send(input logic [SW-1:0] s, input logic [DW-1:0] d, input logic l,
                       output int waits);
      bit acc;
      acc     = 1'b0;
      waits   = 0;
      valid_i = 1'b1;
      sel_i   = s;
      data_i  = d;
      last_i  = l;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         acc = ready_o;
         @(posedge clk);
         #1;
         if (acc) break;
         waits++;
      end
      chk("send_accept", 64'(acc), 64'd1);
      valid_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, n_vec=%0d", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      int w, wsum, c0, d0;
      rst_n = 1'b0; valid_i = 1'b0; data_i = '0; sel_i = '0; last_i = 1'b0; ready_i = '1;
      v3 = 1'b0; d3 = '0; s3 = '0; l3 = 1'b0; r3 = 3'b111;
`ifdef TL_DEMUX_PIPE_BEAT_CNT_EN
      cnt_clr_i = 1'b0; clr3 = 1'b0;
`endif
      #12;
      chk("rst_valid_o", 64'(valid_o), 64'd0);
      chk("rst_lock_o", 64'(lock_o), 64'd0);
      chk("rst_err_o", 64'(err_o), 64'd0);
      chk("rst_data_o", data_o[DW-1:0], 64'd0);
      @(posedge clk); #1; rst_n = 1'b1;
      chk("rst_ready_o", 64'(ready_o), 64'd1);

      // Single beat to port 2.
      send(2'd2, 64'hA5, 1'b1, w);
      chk("single_valid", 64'(valid_o), 64'h4);
      chk("single_data2", data_o[2*DW +: DW], 64'hA5);
      chk("single_lock", 64'(lock_o), 64'd0);
      @(posedge clk); #1;
      chk("single_gone", 64'(valid_o), 64'd0);

      // Full throughput: 8 beats to port 1 with ready held high.
      c0 = cyc; wsum = 0;
      for (int k = 0; k < 8; k++) begin
         send(2'd1, 64'h100 + 64'(k), 1'b1, w);
         wsum += w;
      end
      @(posedge clk); #1;
      chk("tp_waits", 64'(wsum), 64'd0);
      chk("tp_cycles", 64'(cyc - c0), 64'd9);
      chk("tp_drained", 64'(valid_o), 64'd0);

      // Back-pressure: ready_i[1] toggles every cycle.
      d0 = m_deq[1];
      tog_en = 1'b1;
      for (int k = 0; k < 8; k++) send(2'd1, 64'h200 + 64'(k), 1'b1, w);
      for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(negedge clk);
      chk("bp_drained", 64'(exp_q.size()), 64'd0);
      tog_en = 1'b0;
      @(posedge clk); #1; ready_i = '1;
      chk("bp_count", 64'(m_deq[1] - d0), 64'd8);

      // Burst lock: first beat selects 3, later selects ignored.
      send(2'd3, 64'hB0, 1'b0, w);
      chk("burst_lock1", 64'(lock_o), 64'd1);
      chk("burst_v1", 64'(valid_o), 64'h8);
      send(2'd0, 64'hB1, 1'b0, w);
      send(2'd0, 64'hB2, 1'b0, w);
      chk("burst_v3", 64'(valid_o), 64'h8);
      send(2'd0, 64'hB3, 1'b1, w);
      chk("burst_v4", 64'(valid_o), 64'h8);
      chk("burst_d4", data_o[3*DW +: DW], 64'hB3);
      chk("burst_last", 64'(last_o), 64'd1);
      chk("burst_unlock", 64'(lock_o), 64'd0);
      @(posedge clk); #1;

      // Out-of-range select on the N=3 instance.
      v3 = 1'b1; s3 = 2'd3; d3 = 64'h11; l3 = 1'b0;
      @(negedge clk);
      chk("oor_ready1", 64'(ro3), 64'd1);
      @(posedge clk); #1;
      chk("oor_err1", 64'(e3), 64'd1);
      chk("oor_esel", 64'(es3), 64'd3);
      chk("oor_v1", 64'(vo3), 64'd0);
      chk("oor_lock", 64'(lk3), 64'd1);
      s3 = 2'd0; d3 = 64'h22; l3 = 1'b1;
      @(negedge clk);
      chk("oor_ready2", 64'(ro3), 64'd1);
      @(posedge clk); #1;
      chk("oor_err2", 64'(e3), 64'd0);
      chk("oor_v2", 64'(vo3), 64'd0);
      chk("oor_unlock", 64'(lk3), 64'd0);
      chk("oor_esel_hold", 64'(es3), 64'd3);
      s3 = 2'd0; d3 = 64'h33; l3 = 1'b1;
      @(posedge clk); #1;
      v3 = 1'b0;
      chk("oor_next_v", 64'(vo3), 64'd1);
      chk("oor_next_d", do3[DW-1:0], 64'h33);
      chk("oor_next_err", 64'(e3), 64'd0);
      @(posedge clk); #1;
      chk("oor_next_gone", 64'(vo3), 64'd0);

      // Asynchronous reset in the middle of a burst to port 1.
      send(2'd1, 64'hC0, 1'b0, w);
      send(2'd1, 64'hC1, 1'b0, w);
      chk("mid_lock", 64'(lock_o), 64'd1);
      #2; rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(valid_o), 64'd0);
      chk("mid_rst_lock", 64'(lock_o), 64'd0);
      @(posedge clk); #1; rst_n = 1'b1;
      send(2'd2, 64'hC9, 1'b1, w);
      chk("post_rst_valid", 64'(valid_o), 64'h4);
      chk("post_rst_data", data_o[2*DW +: DW], 64'hC9);
      @(posedge clk); #1;

`ifdef TL_DEMUX_PIPE_BEAT_CNT_EN
      for (int k = 0; k < 20; k++) send(2'd0, 64'h300 + 64'(k), 1'b1, w);
      @(posedge clk); #1;
      chk("cnt_sat", 64'(beat_cnt_o[CW-1:0]), 64'd15);
      send(2'd0, 64'h3FF, 1'b1, w);
      cnt_clr_i = 1'b1;
      @(posedge clk); #1;
      cnt_clr_i = 1'b0;
      chk("cnt_clr_deq", 64'(valid_o), 64'd0);
      chk("cnt_clr", 64'(beat_cnt_o[CW-1:0]), 64'd0);
`endif

      repeat (2) @(posedge clk);
      #1;
      chk("final_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
